// File: rtl/dly_chain_cal.sv
// dly_chain_cal: calibration controller for the inverter delay chain that
// sets the I2C SDA hold delay. Launches edges into the chain, counts how far
// each edge travels in one clock, averages over 2^AVG_LOG2 launches and turns
// a requested fraction of the clock period into a tap select.
// Optional feature: define DLY_CAL_PERIODIC_EN for periodic self-recalibration.
module dly_chain_cal #(
  parameter int unsigned TAPS       = 39,
  parameter int unsigned AVG_LOG2   = 3,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned RECAL_LOG2 = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      frac,
  output logic            launch,
  input  logic [TAPS-1:0] tap,
  output logic            busy,
  output logic            done,
  output logic [5:0]      tpc,
  output logic [5:0]      sel,
  output logic            err
);

  localparam int unsigned AW = 6 + AVG_LOG2;
  localparam int unsigned PW = 12 + AVG_LOG2;
  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned NW = AVG_LOG2 + 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [NW-1:0] SAMPLE_LAST = NW'((1 << AVG_LOG2) - 1);
  localparam logic [5:0]    TAPS_W      = 6'(TAPS);
  localparam logic [5:0]    SEL_MAX     = 6'(TAPS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, CAPT, ACC, CALC} state_t;

  state_t          state;
  logic [TAPS-1:0] base;
  logic [TAPS-1:0] snap;
  logic [TAPS-1:0] diff;
  logic [AW-1:0]   acc;
  logic [SW-1:0]   scnt;
  logic [NW-1:0]   ncnt;
  logic [5:0]      run_cnt;
  logic [PW-1:0]   prod;
  logic [5:0]      sel_raw;
  logic [5:0]      sel_new;
  logic            kick;

  // Alternating stage polarity cancels out in the xor of two settled snapshots
  assign diff = base ^ snap;

  // Length of the run of switched stages starting at stage 1; bubbles beyond
  // the first unswitched stage are ignored
  always_comb begin
    logic still;
    run_cnt = '0;
    still   = 1'b1;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (still && diff[i]) begin
        run_cnt = run_cnt + 6'd1;
      end else begin
        still = 1'b0;
      end
    end
  end

  // Tap select from the full-precision sum, clamped to the last tap
  always_comb begin
    prod    = PW'(acc) * PW'(frac);
    sel_raw = prod[PW-1 -: 6];
    sel_new = (sel_raw > SEL_MAX) ? SEL_MAX : sel_raw;
  end

`ifdef DLY_CAL_PERIODIC_EN
  logic [RECAL_LOG2-1:0] idle_cnt;

  // Idle-time counter; its wrap triggers a calibration like start does
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != IDLE || start) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign kick = start || (state == IDLE && idle_cnt == '1);
`else
  assign kick = start;
`endif

  // Calibration sequencer: settle, launch, capture, accumulate, then compute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      launch <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tpc    <= '0;
      sel    <= '0;
      err    <= 1'b0;
      base   <= '0;
      snap   <= '0;
      acc    <= '0;
      scnt   <= '0;
      ncnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (kick) begin
            state <= WAIT;
            busy  <= 1'b1;
            acc   <= '0;
            scnt  <= '0;
            ncnt  <= '0;
            err   <= 1'b0;
          end else begin
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (scnt == SETTLE_LAST) begin
            base   <= tap;
            launch <= ~launch;
            state  <= CAPT;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        CAPT: begin
          snap  <= tap;
          state <= ACC;
        end
        ACC: begin
          acc <= acc + AW'(run_cnt);
          if (run_cnt == TAPS_W) begin
            err <= 1'b1;
          end
          if (ncnt == SAMPLE_LAST) begin
            state <= CALC;
          end else begin
            ncnt  <= ncnt + 1'b1;
            scnt  <= '0;
            state <= WAIT;
          end
        end
        CALC: begin
          tpc   <= acc[AW-1 -: 6];
          sel   <= sel_new;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dly_chain_cal.sv
// Self-checking bench for dly_chain_cal with a behavioural delay-chain driver
// and a timing-level reference model of the calibration outputs.
module tb_dly_chain_cal;

  localparam int TAPS       = 39;
  localparam int AVG_LOG2   = 3;
  localparam int SETTLE     = 4;
  localparam int RECAL_LOG2 = 8;
  localparam int NL         = 1 << AVG_LOG2;
  localparam int PER        = SETTLE + 2;
  localparam int NTOT       = NL * PER + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [5:0]      frac;
  logic            launch;
  logic [TAPS-1:0] tap;
  logic            busy;
  logic            done;
  logic [5:0]      tpc;
  logic [5:0]      sel;
  logic            err;

  dly_chain_cal #(
    .TAPS(TAPS),
    .AVG_LOG2(AVG_LOG2),
    .SETTLE(SETTLE),
    .RECAL_LOG2(RECAL_LOG2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .frac(frac),
    .launch(launch),
    .tap(tap),
    .busy(busy),
    .done(done),
    .tpc(tpc),
    .sel(sel),
    .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural delay chain ----------------
  // mode 0: fixed taps per clock, 1: random taps with bubbles,
  // 2: fixed bubble pattern, 3: random noise on every tap
  int   mode = 3;
  int   fix_t = 20;
  int   toggles = 0;
  int   cq[$];
  logic prev_l = 1'b0;

  function automatic logic [TAPS-1:0] settled(input logic lvl);
    logic [TAPS-1:0] s;
    for (int k = 0; k < TAPS; k++) s[k] = (k % 2 == 0) ? ~lvl : lvl;
    return s;
  endfunction

  always @(posedge clk) begin
    logic [63:0] r;
    logic [63:0] m;
    int          t;
    #1;
    if (mode == 3) begin
      r = {$urandom, $urandom};
      tap = r[TAPS-1:0];
    end else if (rst_n && launch !== prev_l) begin
      toggles++;
      if (mode == 2) begin
        m = 64'h7BFF;
        t = 10;
      end else begin
        t = (mode == 1) ? int'($urandom_range(0, TAPS)) : fix_t;
        if (t >= TAPS) begin
          t = TAPS;
          m = '1;
        end else begin
          r = {$urandom, $urandom};
          m = (64'd1 << t) - 64'd1;
          if (mode == 1) m = m | (r & ~((64'd2 << t) - 64'd1));
        end
      end
      cq.push_back(t);
      tap = settled(prev_l) ^ m[TAPS-1:0];
    end else begin
      tap = settled(launch);
    end
    prev_l = launch;
  end

  // ---------------- reference model ----------------
  bit m_busy, m_done, m_err, m_launch, m_run;
  int m_tpc, m_sel, m_t, m_acc, m_idle;

  always @(posedge clk or negedge rst_n) begin
    int  c;
    bit  go;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_err = 0; m_launch = 0; m_run = 0;
      m_tpc = 0; m_sel = 0; m_t = 0; m_acc = 0; m_idle = 0;
      cq.delete();
    end else begin
      m_done = 0;
      if (m_run) begin
        m_t++;
        m_idle = 0;
        if (m_t >= SETTLE && (m_t - SETTLE) % PER == 0 && (m_t - SETTLE) / PER < NL)
          m_launch = ~m_launch;
        if (m_t >= PER && (m_t - PER) % PER == 0 && (m_t - PER) / PER < NL) begin
          c = (cq.size() > 0) ? cq.pop_front() : 0;
          m_acc += c;
          if (c == TAPS) m_err = 1;
        end
        if (m_t == NTOT) begin
          m_tpc  = m_acc >> AVG_LOG2;
          m_sel  = (m_acc * int'(frac)) >> (6 + AVG_LOG2);
          if (m_sel > TAPS - 1) m_sel = TAPS - 1;
          m_done = 1;
          m_run  = 0;
        end
      end else begin
        go = start;
`ifdef DLY_CAL_PERIODIC_EN
        if (m_idle == (1 << RECAL_LOG2) - 1) go = 1;
`endif
        m_idle = go ? 0 : m_idle + 1;
        m_busy = go;
        if (go) begin
          m_run = 1; m_t = 0; m_acc = 0; m_err = 0;
          cq.delete();
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit chk_en = 0;
  int dcount = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("launch", launch, m_launch);
      chk("busy",   busy,   m_busy);
      chk("done",   done,   m_done);
      chk("tpc",    tpc,    m_tpc);
      chk("sel",    sel,    m_sel);
      chk("err",    err,    m_err);
    end
    if (done === 1'b1) dcount++;
  end

  task automatic run_cal(input logic [5:0] f, output int lat);
    @(posedge clk);
    #1;
    frac    = f;
    start   = 1'b1;
    toggles = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int d0;
    int rise;
    rst_n = 1'b0;
    start = 1'b0;
    frac  = '0;
    mode  = 3;

    // reset with noisy taps
    repeat (2) @(posedge clk);
    chk_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_launch", launch, 0);
    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_tpc",    tpc,    0);
    chk("rst_sel",    sel,    0);
    chk("rst_err",    err,    0);
    @(posedge clk);
    #1;
    mode  = 0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 20 taps per clock, half a period
    fix_t = 20;
    run_cal(6'd32, lat);
    chk("t1_latency", lat, 49);
    chk("t1_tpc", tpc, 20);
    chk("t1_sel", sel, 10);
    chk("t1_err", err, 0);
    chk("t1_toggles", toggles, 8);

    // saturated chain
    fix_t = 45;
    run_cal(6'd63, lat);
    chk("t2_latency", lat, 49);
    chk("t2_tpc", tpc, 39);
    chk("t2_sel", sel, 38);
    chk("t2_err", err, 1);

    // ERR clears on the next calibration
    fix_t = 10;
    run_cal(6'd63, lat);
    chk("t3_tpc", tpc, 10);
    chk("t3_sel", sel, 9);
    chk("t3_err", err, 0);

    // bubble above the first unswitched stage
    mode = 2;
    run_cal(6'd32, lat);
    chk("t4_tpc", tpc, 10);
    chk("t4_sel", sel, 5);

    // start held during a calibration gives one calibration
    mode  = 0;
    fix_t = 20;
    @(posedge clk);
    #1;
    d0    = dcount;
    frac  = 6'd16;
    start = 1'b1;
    repeat (46) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    chk("t5_done_once", dcount - d0, 1);
    chk("t5_sel", sel, 5);

    // reset in the middle of a calibration
    @(posedge clk);
    #1;
    start = 1'b1;
    d0    = dcount;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_sel",  sel,  0);
    chk("t6_tpc",  tpc,  0);
    chk("t6_launch", launch, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    chk("t6_no_done", dcount - d0, 0);
    chk("t6_idle", busy, 0);

    // randomized calibrations checked cycle by cycle against the model
    mode = 1;
    for (int i = 0; i < 8; i++) begin
      run_cal(6'($urandom_range(0, 63)), lat);
      chk("rnd_latency", lat, 49);
    end

    // idle behaviour: periodic self-start only when the feature is built in
    mode = 0;
    fix_t = 12;
    rise = 0;
    for (int i = 0; i < 300 && rise == 0; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) rise = 1;
    end
`ifdef DLY_CAL_PERIODIC_EN
    chk("periodic_start", rise, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("periodic_done", (lat < 200) ? 1 : 0, 1);
    chk("periodic_tpc", tpc, 12);
`else
    chk("no_periodic_start", rise, 0);
`endif
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
